bilateral_window_sequencer: RTL
===============================

Name: bilateral_window_sequencer

Overview:
Controller for the bilateral filter datapath. It raster-scans the image and, for each output pixel, issues the (2R+1)x(2R+1) window taps in row-major order over a valid/ready stream. Each tap carries the spatial-kernel index, used directly as the gaussian_kernel weight select, and the border-clamped source-pixel coordinates. After the last tap it waits for the downstream accumulate/normalise unit to finish before advancing to the next pixel.

Parameters:
IMG_W, 64, image width in pixels (>=1)
IMG_H, 64, image height in pixels (>=1)
R, 3, window radius; K=2R+1=7, NT=K*K=49 taps
XW, $clog2(IMG_W) (min 1), column coordinate width
YW, $clog2(IMG_H) (min 1), row coordinate width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begins a frame when idle, ignored otherwise
abort  in  1  synchronous; returns FSM to IDLE next cycle, no done pulse
busy  out  1  high from accepted start until frame end
done  out  1  one-cycle pulse after the last pixel's acc_done
tap_valid  out  1  tap beat valid
tap_ready  in  1  downstream accepts tap
tap_idx  out  $clog2(NT)  kernel index = (dy+R)*K + (dx+R), 0..NT-1
tap_x  out  XW  clamped source column
tap_y  out  YW  clamped source row
tap_first  out  1  beat is tap 0 of a pixel
tap_last  out  1  beat is tap NT-1 of a pixel
pix_x  out  XW  output pixel column (stable while issuing and waiting)
pix_y  out  YW  output pixel row
acc_done  in  1  pulse; downstream finished current pixel

Behaviour:
- Reset: state IDLE; busy=0, done=0, tap_valid=0, tap_idx=0, tap_first=0, tap_last=0, pix_x=pix_y=0, dx=dy=-R internally.
- States: IDLE, ISSUE, WAIT_ACC, FIN.
- IDLE: start=1 -> ISSUE next cycle; pix=(0,0), tap counter=0; busy=1 from that cycle.
- ISSUE: tap_valid=1. All tap outputs are registered and held stable while tap_valid && !tap_ready. On handshake the counter advances: dx++ ; on dx=R wrap dx=-R, dy++. The next tap is presented the following cycle, giving full throughput of one tap per cycle under constant ready. A handshake with tap_last=1 -> WAIT_ACC, tap_valid=0 next cycle.
- Clamping: tap_x = min(max(pix_x+dx, 0), IMG_W-1); tap_y likewise with IMG_H. Signed arithmetic uses XW+2 / YW+2 bits.
- tap_first = (counter==0); tap_last = (counter==NT-1).
- WAIT_ACC: waits for acc_done. On acc_done: if pix is (IMG_W-1, IMG_H-1) -> FIN; else pix_x++ (wrap to 0 with pix_y++) -> ISSUE, counter reset.
- acc_done outside WAIT_ACC is ignored. This includes acc_done arriving in the same cycle as the tap_last handshake.
- FIN: done=1 for exactly one cycle, busy=0 in the same cycle -> IDLE. A start in FIN is ignored.
- abort (any state except IDLE): next cycle IDLE, tap_valid=0, busy=0, counters reset; done not asserted. abort has priority over all other events.
- Reset mid-frame: immediately returns to the reset values (asynchronous); no partial done.
- Frame latency with tap_ready=1 and acc_done returned L cycles after tap_last: (NT+1+L) cycles per pixel + 1 cycle FIN.

Test Plan:
- Reset/idle: hold rst_n=0, then release with no start -> busy=0, tap_valid=0, done=0 for 20 cycles.
- Interior pixel (IMG_W=IMG_H=16, R=3, ready=1): at pix (8,8) taps 0..48 on consecutive cycles. Tap 0 -> (5,5) idx0 first=1; tap 24 -> (8,8); tap 48 -> (11,11) idx48 last=1.
- Corner clamping: pix (0,0) -> tap0 (0,0), tap 10 (dx=0,dy=-2) -> (0,0), tap 48 -> (3,3). Pix (15,15) tap 48 -> (15,15).
- Backpressure: random tap_ready 50% -> tap fields stable while stalled, exactly 49 handshakes per pixel, idx sequence 0..48 without gaps or repeats.
- Full frame IMG_W=4, IMG_H=3, acc_done 5 cycles after tap_last -> 12 pixels in raster order, single done pulse, busy falls with done, total = 12*(49+1+5)+1 cycles from start.
- Abort/stray events: abort at pixel 5 tap 20 -> IDLE next cycle, no done; restart begins at pix (0,0) tap 0. An acc_done pulse during ISSUE is ignored, and the pixel still waits for a later acc_done.

Source files
------------

// File: rtl/bilateral_window_sequencer_if.sv
// Tap stream between the window sequencer and the bilateral filter datapath.
//   master (sequencer): tap_valid, tap_idx, tap_x, tap_y, tap_first, tap_last,
//                       pix_x, pix_y out; tap_ready, acc_done in
//   slave  (datapath) : the mirror image
interface bilateral_window_sequencer_if #(
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64,
  parameter int unsigned R     = 3
);
  localparam int unsigned K  = 2 * R + 1;
  localparam int unsigned NT = K * K;
  localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned IW = (NT > 1) ? $clog2(NT) : 1;

  logic          tap_valid;
  logic          tap_ready;
  logic [IW-1:0] tap_idx;
  logic [XW-1:0] tap_x;
  logic [YW-1:0] tap_y;
  logic          tap_first;
  logic          tap_last;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          acc_done;

  modport master (
    output tap_valid, tap_idx, tap_x, tap_y, tap_first, tap_last, pix_x, pix_y,
    input  tap_ready, acc_done
  );

  modport slave (
    input  tap_valid, tap_idx, tap_x, tap_y, tap_first, tap_last, pix_x, pix_y,
    output tap_ready, acc_done
  );
endinterface

// File: rtl/bilateral_window_sequencer.sv
// Raster-scans the image and, per output pixel, issues the (2R+1)^2 window taps
// row-major with border-clamped source coordinates, then waits for acc_done.
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   start       : begins a frame when idle
//   abort       : returns to idle next cycle, no done pulse
//   busy        : frame in progress
//   done        : one-cycle pulse at frame end
//   tap         : tap stream (master modport), see bilateral_window_sequencer_if
module bilateral_window_sequencer #(
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64,
  parameter int unsigned R     = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  bilateral_window_sequencer_if.master tap
);
  localparam int unsigned K   = 2 * R + 1;
  localparam int unsigned NT  = K * K;
  localparam int unsigned XW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned IW  = (NT > 1) ? $clog2(NT) : 1;
  localparam int unsigned CW  = $clog2(R + 1) + 1;
  localparam int unsigned SXW = ((XW > CW) ? XW : CW) + 2;
  localparam int unsigned SYW = ((YW > CW) ? YW : CW) + 2;

  localparam logic signed [CW-1:0] DMAX = CW'(R);
  localparam logic signed [CW-1:0] DMIN = -DMAX;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACC = 2'd2,
    FIN      = 2'd3
  } state_t;

  state_t state, nxt_state;

  logic [IW-1:0]        cnt, nxt_cnt;
  logic signed [CW-1:0] dx, dy, nxt_dx, nxt_dy;
  logic [XW-1:0]        pix_x_q, nxt_px;
  logic [YW-1:0]        pix_y_q, nxt_py;

  logic          busy_q, done_q, valid_q, first_q, last_q;
  logic [IW-1:0] idx_q;
  logic [XW-1:0] tap_x_q;
  logic [YW-1:0] tap_y_q;

  logic hs, last_tap, last_pix;

  assign hs       = valid_q && tap.tap_ready;
  assign last_tap = (cnt == IW'(NT - 1));
  assign last_pix = (pix_x_q == XW'(IMG_W - 1)) && (pix_y_q == YW'(IMG_H - 1));

  // Source column/row clamped into the image; sums carry two guard bits.
  function automatic logic [XW-1:0] clamp_x(input logic [XW-1:0] p,
                                            input logic signed [CW-1:0] d);
    logic signed [SXW-1:0] s;
    s = $signed(SXW'(p)) + SXW'(d);
    if (s < 0)                                clamp_x = '0;
    else if (s > $signed(SXW'(IMG_W - 1)))    clamp_x = XW'(IMG_W - 1);
    else                                      clamp_x = XW'(s);
  endfunction

  function automatic logic [YW-1:0] clamp_y(input logic [YW-1:0] p,
                                            input logic signed [CW-1:0] d);
    logic signed [SYW-1:0] s;
    s = $signed(SYW'(p)) + SYW'(d);
    if (s < 0)                                clamp_y = '0;
    else if (s > $signed(SYW'(IMG_H - 1)))    clamp_y = YW'(IMG_H - 1);
    else                                      clamp_y = YW'(s);
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  // Next-state logic; abort outranks every other event
  always_comb begin
    nxt_state = state;
    if (abort && (state != IDLE)) begin
      nxt_state = IDLE;
    end else begin
      case (state)
        IDLE:     if (start) nxt_state = ISSUE;
        ISSUE:    if (hs && last_tap) nxt_state = WAIT_ACC;
        WAIT_ACC: if (tap.acc_done) nxt_state = last_pix ? FIN : ISSUE;
        FIN:      nxt_state = IDLE;
        default:  nxt_state = IDLE;
      endcase
    end
  end

  // Next tap counter / window offset / pixel position
  always_comb begin
    nxt_cnt = cnt;
    nxt_dx  = dx;
    nxt_dy  = dy;
    nxt_px  = pix_x_q;
    nxt_py  = pix_y_q;
    if (nxt_state == IDLE) begin
      nxt_cnt = '0;
      nxt_dx  = DMIN;
      nxt_dy  = DMIN;
      nxt_px  = '0;
      nxt_py  = '0;
    end else if ((state == ISSUE) && hs) begin
      // Window rewinds on the last tap so the next pixel starts at tap 0.
      if (last_tap) begin
        nxt_cnt = '0;
        nxt_dx  = DMIN;
        nxt_dy  = DMIN;
      end else begin
        nxt_cnt = cnt + IW'(1);
        if (dx == DMAX) begin
          nxt_dx = DMIN;
          nxt_dy = dy + CW'(1);
        end else begin
          nxt_dx = dx + CW'(1);
        end
      end
    end else if ((state == WAIT_ACC) && (nxt_state == ISSUE)) begin
      if (pix_x_q == XW'(IMG_W - 1)) begin
        nxt_px = '0;
        nxt_py = pix_y_q + YW'(1);
      end else begin
        nxt_px = pix_x_q + XW'(1);
      end
    end
  end

  // Registered datapath and outputs, loaded from next-cycle values so a
  // stalled beat holds every field unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      dx      <= DMIN;
      dy      <= DMIN;
      pix_x_q <= '0;
      pix_y_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      tap_x_q <= '0;
      tap_y_q <= '0;
    end else begin
      cnt     <= nxt_cnt;
      dx      <= nxt_dx;
      dy      <= nxt_dy;
      pix_x_q <= nxt_px;
      pix_y_q <= nxt_py;
      busy_q  <= (nxt_state == ISSUE) || (nxt_state == WAIT_ACC);
      done_q  <= (nxt_state == FIN);
      valid_q <= (nxt_state == ISSUE);
      first_q <= (nxt_state == ISSUE) && (nxt_cnt == '0);
      last_q  <= (nxt_state == ISSUE) && (nxt_cnt == IW'(NT - 1));
      idx_q   <= nxt_cnt;
      tap_x_q <= clamp_x(nxt_px, nxt_dx);
      tap_y_q <= clamp_y(nxt_py, nxt_dy);
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign tap.tap_valid = valid_q;
  assign tap.tap_idx   = idx_q;
  assign tap.tap_x     = tap_x_q;
  assign tap.tap_y     = tap_y_q;
  assign tap.tap_first = first_q;
  assign tap.tap_last  = last_q;
  assign tap.pix_x     = pix_x_q;
  assign tap.pix_y     = pix_y_q;
endmodule
